// File: rtl/fb_ctrl_pkg.sv
// Shared types and default widths for the LED framebuffer double-buffer controller.
package fb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    CLEAR      = 2'd2,
    ACK        = 2'd3
  } FbSwapState;

  localparam int FB_ADDR_W = 11;
  localparam int FB_DATA_W = 8;

endpackage

// File: rtl/led_framebuffer_ctrl.sv
// Double-buffer controller: CPU writes go to the back bank, banks flip on scanner frame end, optional back-bank clear.
// Write path is combinational; cpu_ready drops for DEPTH cycles while a clear runs and the CPU must hold its write.
module led_framebuffer_ctrl
  import fb_ctrl_pkg::*;
#(
  parameter int                ADDR_W      = FB_ADDR_W,
  parameter int                DATA_W      = FB_DATA_W,
  parameter int                DEPTH       = 2048,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_wr_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              cpu_ready,
  input  logic              swap_req,
  input  logic              clear_on_swap,
  output logic              swap_busy,
  output logic              swap_ack,
  input  logic              frame_done,
  output logic              front_sel,
  output logic              bank0_we,
  output logic [ADDR_W-1:0] bank0_waddr,
  output logic [DATA_W-1:0] bank0_wdata,
  output logic              bank1_we,
  output logic [ADDR_W-1:0] bank1_waddr,
  output logic [DATA_W-1:0] bank1_wdata
);

  // One extra counter bit so DEPTH == 2**ADDR_W reaches its last index without wrapping.
  localparam int               CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(DEPTH - 1);

  FbSwapState        state_q;
  logic              front_sel_q;
  logic              clear_pending_q;
  logic [CNT_W-1:0]  clr_cnt_q;
  logic [CNT_W-1:0]  clr_cnt_d;

  logic              wr_en_c;
  logic [ADDR_W-1:0] waddr_c;
  logic [DATA_W-1:0] wdata_c;

  assign clr_cnt_d = clr_cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      front_sel_q     <= 1'b0;
      clear_pending_q <= 1'b0;
      clr_cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (swap_req) begin
            clear_pending_q <= clear_on_swap;
            state_q         <= WAIT_FRAME;
          end
        end
        WAIT_FRAME: begin
          if (frame_done) begin
            front_sel_q <= ~front_sel_q;
            state_q     <= clear_pending_q ? CLEAR : ACK;
          end
        end
        CLEAR: begin
          if (clr_cnt_q == CLR_LAST) begin
            clr_cnt_q <= '0;
            state_q   <= ACK;
          end else begin
            clr_cnt_q <= clr_cnt_d;
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The clear engine owns the back-bank port; otherwise the CPU does.
  always_comb begin
    wr_en_c = 1'b0;
    waddr_c = cpu_addr;
    wdata_c = cpu_wr_data;
    if (state_q == CLEAR) begin
      wr_en_c = 1'b1;
      waddr_c = clr_cnt_q[ADDR_W-1:0];
      wdata_c = CLEAR_VALUE;
    end else if (cpu_wr_en) begin
      wr_en_c = 1'b1;
    end
  end

  assign bank0_we    = wr_en_c & front_sel_q;
  assign bank1_we    = wr_en_c & ~front_sel_q;
  assign bank0_waddr = waddr_c;
  assign bank1_waddr = waddr_c;
  assign bank0_wdata = wdata_c;
  assign bank1_wdata = wdata_c;

  assign front_sel = front_sel_q;
  assign cpu_ready = (state_q != CLEAR);
  assign swap_busy = (state_q != IDLE);
  assign swap_ack  = (state_q == ACK);

endmodule
